// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM encodings, divider
// handshake levels and the latched operand record.
package div_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_ABORT = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   typedef struct packed {
      logic        sgn;
      logic [31:0] op1;
      logic [31:0] op2;
   } div_opr_t;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick. last_i names the requester favoured on
// a tie; the owner of last_i flips it to the loser after every grant.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o,
   output logic       idx_o
);

   always_comb begin
      idx_o = (req_i == 2'b11) ? last_i : req_i[1];
      gnt_o = 2'b00;
      if (req_i != 2'b00) gnt_o = idx_o ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters: round-robin grant,
// operand latching, annul on owner flush and a settle window after each op.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int DRAIN_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_i,
   input  logic [1:0]  signed_i,
   input  logic [31:0] op1_0_i,
   input  logic [31:0] op2_0_i,
   input  logic [31:0] op1_1_i,
   input  logic [31:0] op2_1_i,
   input  logic [1:0]  flush_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  resp_valid_o,
   output logic [63:0] result_o,
   output logic        busy_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i
);

   // DRAIN_CYC must be at least 1; the counter counts down to zero.
   localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYC - 1);

   state_e          state_q, state_d;
   logic            last_q, last_d;
   logic            owner_q, owner_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [1:0]      resp_q, resp_d;
   logic [63:0]     result_q, result_d;
   div_opr_t        opr_q, opr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            start_q, start_d;
   logic            annul_q, annul_d;
   logic            busy_q, busy_d;

   logic [1:0]      arb_gnt;
   logic            arb_idx;

   rr_arb2 u_rr (
      .req_i  (req_i & ~flush_i),
      .last_i (last_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      gnt_d    = gnt_q;
      resp_d   = 2'b00;
      result_d = result_q;
      opr_d    = opr_q;
      cnt_d    = cnt_q;
      annul_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arb_gnt != 2'b00) begin
               state_d = S_BUSY;
               owner_d = arb_idx;
               gnt_d   = arb_gnt;
               last_d  = ~arb_idx;
               opr_d   = arb_idx ? '{signed_i[1], op1_1_i, op2_1_i}
                                 : '{signed_i[0], op1_0_i, op2_0_i};
            end
         end
         S_BUSY: begin
            // Flush beats a same-cycle ready; that result is dropped.
            if (flush_i[owner_q]) begin
               state_d = S_ABORT;
               cnt_d   = CNT_INIT;
               annul_d = 1'b1;
            end else if (div_ready_i == DivResultReady) begin
               state_d  = S_DRAIN;
               cnt_d    = CNT_INIT;
               result_d = div_result_i;
               resp_d   = owner_q ? 2'b10 : 2'b01;
               gnt_d    = 2'b00;
            end
         end
         S_ABORT, S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               gnt_d   = 2'b00;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      start_d = (state_d == S_BUSY) ? DivStart : DivStop;
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b0;
         owner_q  <= 1'b0;
         gnt_q    <= 2'b00;
         resp_q   <= 2'b00;
         result_q <= '0;
         opr_q    <= '0;
         cnt_q    <= '0;
         start_q  <= DivStop;
         annul_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         resp_q   <= resp_d;
         result_q <= result_d;
         opr_q    <= opr_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         annul_q  <= annul_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt_o        = gnt_q;
   assign resp_valid_o = resp_q;
   assign result_o     = result_q;
   assign busy_o       = busy_q;
   assign div_start_o  = start_q;
   assign div_annul_o  = annul_q;
   assign div_signed_o = opr_q.sgn;
   assign div_op1_o    = opr_q.op1;
   assign div_op2_o    = opr_q.op2;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural iterative divider.
module tb_div_arbiter;

   localparam int DRAIN_CYC = 2;
   localparam int LAT       = 16;
   localparam int TMO       = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_i = 2'b00;
   logic [1:0]  signed_i = 2'b00;
   logic [31:0] op1_0_i = '0, op2_0_i = '0, op1_1_i = '0, op2_1_i = '0;
   logic [1:0]  flush_i = 2'b00;
   logic [1:0]  gnt_o, resp_valid_o;
   logic [63:0] result_o;
   logic        busy_o, div_start_o, div_annul_o, div_signed_o;
   logic [31:0] div_op1_o, div_op2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   div_arbiter #(.DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .signed_i(signed_i),
      .op1_0_i(op1_0_i), .op2_0_i(op2_0_i), .op1_1_i(op1_1_i), .op2_1_i(op2_1_i),
      .flush_i(flush_i), .gnt_o(gnt_o), .resp_valid_o(resp_valid_o),
      .result_o(result_o), .busy_o(busy_o), .div_start_o(div_start_o),
      .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
      .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int resp_cnt = 0;

   typedef struct {
      int          idx;
      logic [63:0] res;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int          idx;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      string       nm;
   } vec_t;
   vec_t vecs[6];

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Behavioural divider: result after LAT cycles of continuous start.
   initial begin
      int dcnt;
      dcnt = 0;
      div_ready_i = 1'b0;
      div_result_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (div_start_o) begin
            dcnt++;
            if (dcnt == LAT) begin
               div_ready_i  = 1'b1;
               div_result_i = div_model(div_signed_o, div_op1_o, div_op2_o);
            end else begin
               div_ready_i = 1'b0;
            end
         end else begin
            dcnt = 0;
            div_ready_i = 1'b0;
         end
      end
   end

   // Scoreboard and per-cycle invariants.
   always @(negedge clk) begin
      if (rst) begin
         chk("gnt_onehot0", 64'($onehot0(gnt_o)), 64'd1);
         chk("annul_vs_start", 64'(div_annul_o & div_start_o), 64'd0);
         if (resp_valid_o != 2'b00) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp actual=%b required=none", resp_valid_o);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("resp_owner", 64'(resp_valid_o), (e.idx == 1) ? 64'd2 : 64'd1);
               chk("resp_result", result_o, e.res);
            end
         end
      end
   end

   task automatic chk_reset_vals();
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_resp", 64'(resp_valid_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_start", 64'(div_start_o), 64'd0);
      chk("rst_annul", 64'(div_annul_o), 64'd0);
      chk("rst_signed", 64'(div_signed_o), 64'd0);
      chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (n == TMO) chk("idle_timeout", 64'(busy_o), 64'd0);
   endtask

   task automatic wait_bit(input string nm, input int which);
      int n = 0;
      while (n < TMO) begin
         if (which < 2 && resp_valid_o[which]) break;
         if (which >= 2 && gnt_o[which-2]) break;
         @(negedge clk);
         n++;
      end
      if (n == TMO) chk(nm, 64'd0, 64'd1);
   endtask

   task automatic run_op(input int idx, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input string nm);
      wait_idle();
      if (idx == 0) begin
         op1_0_i = a; op2_0_i = b;
      end else begin
         op1_1_i = a; op2_1_i = b;
      end
      signed_i[idx] = sgn;
      req_i[idx]    = 1'b1;
      exp_q.push_back('{idx, exp});
      @(negedge clk);
      chk({nm, "_gnt"}, 64'(gnt_o), (idx == 1) ? 64'd2 : 64'd1);
      chk({nm, "_start"}, 64'(div_start_o), 64'd1);
      chk({nm, "_ops"}, {div_op1_o, div_op2_o}, {a, b});
      wait_bit({nm, "_resp_timeout"}, idx);
      req_i[idx] = 1'b0;
      @(negedge clk);
      chk({nm, "_pulse1"}, 64'(resp_valid_o), 64'd0);
      repeat (DRAIN_CYC) @(negedge clk);
      chk({nm, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      int c0, c1, ann, rc;
      vecs[0] = '{0, 1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, "udiv"};
      vecs[1] = '{1, 1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, "sdiv"};
      vecs[2] = '{0, 1'b0, 32'd5,          32'd0,          64'h00000000_00000000, "divz"};
      vecs[3] = '{1, 1'b0, 32'hFFFFFFFF,   32'd10,         64'h00000005_19999999, "umax"};
      vecs[4] = '{0, 1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, "sneg"};
      vecs[5] = '{1, 1'b1, 32'd5,          32'd0,          64'h00000000_00000000, "sdivz"};

      #2;
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Contention straight out of reset: req0 first, req1 DRAIN_CYC+1 after.
      op1_0_i = 32'd100;        op2_0_i = 32'd7;
      op1_1_i = 32'hFFFFFFF9;   op2_1_i = 32'd2;
      signed_i = 2'b10;
      req_i = 2'b11;
      exp_q.push_back('{0, 64'h00000002_0000000E});
      exp_q.push_back('{1, 64'hFFFFFFFF_FFFFFFFD});
      @(negedge clk);
      chk("tie_gnt0", 64'(gnt_o), 64'd1);
      wait_bit("tie_resp0_timeout", 0);
      c0 = cyc;
      req_i[0] = 1'b0;
      wait_bit("tie_gnt1_timeout", 3);
      c1 = cyc;
      chk("tie_gap", 64'(c1 - c0), 64'(DRAIN_CYC + 1));
      wait_bit("tie_resp1_timeout", 1);
      req_i[1] = 1'b0;
      signed_i = 2'b00;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].idx, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

      // Owner flush mid-op: one annul pulse, no response, then a clean op.
      wait_idle();
      rc = resp_cnt;
      op1_0_i = 32'd1000; op2_0_i = 32'd3; signed_i[0] = 1'b0;
      req_i[0] = 1'b1;
      @(negedge clk);
      chk("flush_gnt", 64'(gnt_o), 64'd1);
      repeat (10) @(negedge clk);
      flush_i[0] = 1'b1;
      req_i[0] = 1'b0;
      @(negedge clk);
      flush_i[0] = 1'b0;
      ann = 0;
      for (int k = 0; k < 8; k++) begin
         if (div_annul_o) ann++;
         @(negedge clk);
      end
      chk("flush_annul_once", 64'(ann), 64'd1);
      repeat (LAT) @(negedge clk);
      chk("flush_no_resp", 64'(resp_cnt - rc), 64'd0);
      run_op(0, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "post_flush");

      // Asynchronous reset in the middle of an operation.
      wait_idle();
      op1_1_i = 32'd50; op2_1_i = 32'd5; signed_i[1] = 1'b0;
      req_i[1] = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 64'(busy_o), 64'd1);
      #2 rst = 1'b0;
      #1 chk_reset_vals();
      @(negedge clk);
      req_i[1] = 1'b0;
      rst = 1'b1;
      rc = resp_cnt;
      repeat (LAT + 10) @(negedge clk);
      chk("rst_no_resp", 64'(resp_cnt - rc), 64'd0);
      chk("rst_idle", 64'(busy_o), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
